// File: rtl/if_stage.sv
// if_stage: instruction fetch stage, single-outstanding REQ/WAIT/HOLD fetch FSM with branch cancel.
// Define FS_PERF_CNT_EN to add the perf_fetch_cnt / perf_cancel_cnt counter outputs.
`ifndef FS_TO_DS_BUS_WD
`define FS_TO_DS_BUS_WD 64
`endif
module if_stage (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ds_allowin,
  input  logic [32:0]                 br_bus,
  output logic                        fs_to_ds_valid,
  output logic [`FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  output logic                        inst_sram_req,
  output logic                        inst_sram_wr,
  output logic [1:0]                  inst_sram_size,
  output logic [31:0]                 inst_sram_addr,
  input  logic                        inst_sram_addr_ok,
  input  logic                        inst_sram_data_ok,
  input  logic [31:0]                 inst_sram_rdata
`ifdef FS_PERF_CNT_EN
  ,
  output logic [31:0]                 perf_fetch_cnt,
  output logic [31:0]                 perf_cancel_cnt
`endif
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;
  state_t state, state_nxt;
  logic [31:0] fetch_pc, pc_nxt;
  logic cancel, cancel_nxt;
  logic [`FS_TO_DS_BUS_WD-1:0] inst_buf;
  logic br_taken, handoff, drop, latch;
  logic [31:0] br_target;
  assign br_taken  = br_bus[32];
  assign br_target = br_bus[31:0];
  assign handoff   = state == S_HOLD && ds_allowin && !br_taken;
  assign drop      = (state == S_WAIT && inst_sram_data_ok && (cancel || br_taken)) || (state == S_HOLD && br_taken);
  assign latch     = state == S_WAIT && inst_sram_data_ok && !cancel && !br_taken;
  always_comb begin
    pc_nxt     = br_taken ? br_target : handoff ? fetch_pc + 32'd4 : fetch_pc;
    state_nxt  = state;
    cancel_nxt = 1'b0;
    case (state)
      S_REQ: begin
        state_nxt  = inst_sram_addr_ok ? S_WAIT : S_REQ;
        cancel_nxt = inst_sram_addr_ok && br_taken;
      end
      S_WAIT: begin
        state_nxt  = !inst_sram_data_ok ? S_WAIT : (cancel || br_taken) ? S_REQ : S_HOLD;
        cancel_nxt = !inst_sram_data_ok && (cancel || br_taken);
      end
      default: state_nxt = (br_taken || ds_allowin) ? S_REQ : S_HOLD;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_REQ;
      fetch_pc <= 32'h1C00_0000;
      cancel   <= 1'b0;
      inst_buf <= '0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= pc_nxt;
      cancel   <= cancel_nxt;
      if (latch) inst_buf <= {inst_sram_rdata, fetch_pc};
    end
  end
  // Valid is a decode of the state register, so it carries no input-to-output path.
  assign fs_to_ds_valid = state == S_HOLD;
  assign fs_to_ds_bus   = inst_buf;
  assign inst_sram_req  = state == S_REQ;
  assign inst_sram_wr   = 1'b0;
  assign inst_sram_size = 2'd2;
  assign inst_sram_addr = fetch_pc;
`ifdef FS_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch_cnt  <= '0;
      perf_cancel_cnt <= '0;
    end else begin
      if (handoff) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (drop) perf_cancel_cnt <= perf_cancel_cnt + 32'd1;
    end
  end
`endif
endmodule
